alu_writeback: RTL
==================

Name: alu_writeback

Overview:
- Stage directly downstream of the ALU.
- Accepts each ALU result and its flags through a valid/ready handshake.
- Updates the processor status register (PSR) according to the operation class.
- Arbitrates the single register-file write port against memory-load writebacks, which always win.
- A one-entry holding buffer absorbs write-port conflicts.
- Also provides branch-condition evaluation from the registered PSR.

Parameters:
- DATA_W, 16, datapath width
- REG_AW, 4, register index width (16 registers)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  ALU result presented
- in_ready  output  1  stage can accept this cycle
- in_result  input  DATA_W  ALU result
- in_aluControl  input  4  ALU opcode for this result
- in_C, in_L, in_F, in_Z, in_N  input  1 each  ALU flags
- in_wr  input  1  result is to be written to a register
- in_rd  input  REG_AW  destination register
- mem_valid  input  1  load data must be written this cycle
- mem_rd  input  REG_AW  load destination
- mem_data  input  DATA_W  load data
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  REG_AW  write address (registered)
- rf_wdata  output  DATA_W  write data (registered)
- psr  output  5  {N,Z,F,L,C} (registered)
- cond  input  4  branch condition code
- cond_true  output  1  condition satisfied by current psr (combinational)

Behaviour:
- Reset is synchronous, active-low; clk is the only clock.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, psr=0, buffer empty.
- Reset mid-operation discards the buffered write.
- Accept: accept = in_valid && in_ready.
- in_ready = !buf_valid || !mem_valid. Combinational, no dependence on in_valid.
- PSR update on accept, visible the next cycle. It depends on in_aluControl:
  - 0001 (SUB) and 1000 (ADD): load C,F; hold L,Z,N.
  - 0010 (CMP): load L,Z,N; hold C,F.
  - 0011/0100/0101 (logic) and all other codes: psr unchanged.
- Write enable: CMP (0010) never writes a register; in_wr is ignored for it. The effective write flag is wr_eff = in_wr && (in_aluControl != 0010).
- Write-port source selection each cycle, in priority order; the chosen source is registered into rf_* at the next edge:
  1. mem_valid: write mem_rd/mem_data.
  2. else buf_valid: write the buffer contents; buffer empties.
  3. else accept && wr_eff: write in_rd/in_result directly (latency 1).
  4. else rf_we=0 next cycle. rf_waddr/rf_wdata hold their previous values.
- An accepted write that is not selected this cycle loads the buffer.
  - This happens when mem_valid=1 with the buffer empty.
  - It also happens when buf_valid=1 with mem_valid=0: the buffer drains and reloads in the same cycle.
- Buffer is never overwritten while full and undrained; in_ready guarantees this.
- Ordering: ALU writes retire in acceptance order.
- A load and an ALU write to the same register in the same cycle: the load writes first, the ALU value lands later and is final.
- No combinational path from in_* to rf_*.
- cond_true is a function of psr only; flags from the current accept are not forwarded.
  - 0000 Z
  - 0001 !Z
  - 0010 C
  - 0011 !C
  - 0100 L
  - 0101 !L
  - 0110 F
  - 0111 !F
  - 1000 N
  - 1001 !N
  - 1110 1
  - all others 0

Decomposition:
- Shared package holds:
  - ALU opcode constants: OP_NOP 0000, OP_SUB 0001, OP_CMP 0010, OP_AND 0011, OP_OR 0100, OP_XOR 0101, OP_ADD 1000.
  - Condition-code constants.
  - PSR bit indices: C=0, L=1, F=2, Z=3, N=4.
- One sub-module: alu_cond_eval, a combinational psr+cond to cond_true decoder, reused by the branch unit.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 → psr=0, rf_we=0, in_ready=1. Release reset with the buffer empty.
- ADD direct write: in_valid=1, aluControl=1000, result=0x0003, C=F=1, in_wr=1, rd=5, mem_valid=0 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0003, psr=5'b00101. One cycle later rf_we=0.
- CMP:
  - Preset psr C=1. Accept aluControl=0010, Z=1, L=N=0, in_wr=1 → rf_we stays 0, psr=5'b01001.
  - cond=0000 → cond_true=1.
  - cond=0011 → cond_true=0.
- Conflict:
  - Cycle 0: mem_valid=1 (rd=2, 0xAAAA) with ALU write to rd=2, 0x1234 → accepted.
  - Cycle 1: rf writes 2/0xAAAA; buffer full. mem_valid=1 again → in_ready=0.
  - Cycle 2: mem_valid=0 → buffer drains; rf writes 2/0x1234 at the next edge.
- Back-to-back: 4 consecutive ALU writes (rd 1..4) with a mem_valid pulse in cycle 1 → all 5 writes appear, ALU order 1,2,3,4 preserved. in_ready never deasserts.
- Reset with buffer full → rf_we=0 after reset; the buffered write is never issued.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// rtl/alu_writeback_pkg.sv - shared opcodes, condition codes and PSR layout for ALU writeback
package alu_writeback_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_ADD = 4'b1000;

  localparam logic [3:0] CC_Z  = 4'b0000;
  localparam logic [3:0] CC_NZ = 4'b0001;
  localparam logic [3:0] CC_C  = 4'b0010;
  localparam logic [3:0] CC_NC = 4'b0011;
  localparam logic [3:0] CC_L  = 4'b0100;
  localparam logic [3:0] CC_NL = 4'b0101;
  localparam logic [3:0] CC_F  = 4'b0110;
  localparam logic [3:0] CC_NF = 4'b0111;
  localparam logic [3:0] CC_N  = 4'b1000;
  localparam logic [3:0] CC_NN = 4'b1001;
  localparam logic [3:0] CC_AL = 4'b1110;

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_MEM,
    WB_BUF,
    WB_ALU
  } wb_src_t;

  // Arithmetic ops own C/F, compare owns L/Z/N; everything else leaves the PSR alone.
  function automatic logic [4:0] psr_update(input logic [4:0] psr, input logic [3:0] op,
                                            input logic c, input logic l, input logic f,
                                            input logic z, input logic n);
    logic [4:0] p;
    p = psr;
    case (op)
      OP_SUB, OP_ADD: begin
        p[PSR_C] = c;
        p[PSR_F] = f;
      end
      OP_CMP: begin
        p[PSR_L] = l;
        p[PSR_Z] = z;
        p[PSR_N] = n;
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/alu_writeback_cond.sv
// rtl/alu_writeback_cond.sv - combinational branch-condition decoder over the PSR
module alu_cond_eval
  import alu_writeback_pkg::*;
(
  input  logic [4:0] psr,
  input  logic [3:0] cond,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      CC_Z:    cond_true =  psr[PSR_Z];
      CC_NZ:   cond_true = !psr[PSR_Z];
      CC_C:    cond_true =  psr[PSR_C];
      CC_NC:   cond_true = !psr[PSR_C];
      CC_L:    cond_true =  psr[PSR_L];
      CC_NL:   cond_true = !psr[PSR_L];
      CC_F:    cond_true =  psr[PSR_F];
      CC_NF:   cond_true = !psr[PSR_F];
      CC_N:    cond_true =  psr[PSR_N];
      CC_NN:   cond_true = !psr[PSR_N];
      CC_AL:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback with PSR update, load-priority write port and holding buffer
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_aluControl,
  input  logic              in_C,
  input  logic              in_L,
  input  logic              in_F,
  input  logic              in_Z,
  input  logic              in_N,
  input  logic              in_wr,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [4:0]        psr,
  input  logic [3:0]        cond,
  output logic              cond_true
);

  logic              buf_valid;
  logic [REG_AW-1:0] buf_rd;
  logic [DATA_W-1:0] buf_data;
  logic              accept;
  logic              alu_write;
  logic              load_buf;
  wb_src_t           src;

  // A full buffer can only be blocked by a load; otherwise it drains this cycle.
  assign in_ready  = !buf_valid || !mem_valid;
  assign accept    = in_valid && in_ready;
  assign alu_write = accept && in_wr && (in_aluControl != OP_CMP);

  always_comb begin
    src = WB_NONE;
    if (mem_valid)      src = WB_MEM;
    else if (buf_valid) src = WB_BUF;
    else if (alu_write) src = WB_ALU;
  end

  assign load_buf = alu_write && (src != WB_ALU);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      psr       <= '0;
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
    end else begin
      case (src)
        WB_MEM: begin
          rf_we    <= 1'b1;
          rf_waddr <= mem_rd;
          rf_wdata <= mem_data;
        end
        WB_BUF: begin
          rf_we    <= 1'b1;
          rf_waddr <= buf_rd;
          rf_wdata <= buf_data;
        end
        WB_ALU: begin
          rf_we    <= 1'b1;
          rf_waddr <= in_rd;
          rf_wdata <= in_result;
        end
        default: rf_we <= 1'b0;
      endcase

      if (accept)
        psr <= psr_update(psr, in_aluControl, in_C, in_L, in_F, in_Z, in_N);

      // Drain and reload may coincide; the reload wins so ordering is kept.
      if (load_buf) begin
        buf_valid <= 1'b1;
        buf_rd    <= in_rd;
        buf_data  <= in_result;
      end else if (src == WB_BUF) begin
        buf_valid <= 1'b0;
      end
    end
  end

  alu_cond_eval u_cond (
    .psr       (psr),
    .cond      (cond),
    .cond_true (cond_true)
  );

endmodule
